mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the CPU's single unified memory port between the instruction-fetch stage and the data-memory stage. It sits between the pipeline and the memory inside the CPU core. It registers the granted request onto a req/ack memory interface that supports variable latency, and it returns a one-cycle acknowledge plus read data to the owner. It also drives per-requester stall signals to the hazard logic.

## Interface
Parameters:
- ADDR_WIDTH, 32, memory byte-address width
- DATA_WIDTH, 32, memory data width

Ports:
- clk  in  1  main clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid this cycle
- if_rdata  out  DATA_WIDTH  fetched instruction, registered
- if_stall  out  1  if_req & ~if_ack (combinational)
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_ack  out  1  one-cycle pulse: data access done
- dm_rdata  out  DATA_WIDTH  load data, registered
- dm_stall  out  1  dm_req & ~dm_ack (combinational)
- mem_cs  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_WIDTH  registered
- mem_wdata  out  DATA_WIDTH  registered
- mem_rdata  in  DATA_WIDTH  valid when mem_ack = 1
- mem_ack  in  1  memory completion; may rise in the first mem_cs cycle
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE
  - IF_BUSY
  - DM_BUSY
- last_owner register (IF/DM):
  - Reset value IF, so data wins the first tie.
- Arbitration: performed in IDLE, and in a BUSY state on the mem_ack cycle.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one that is not last_owner (alternating).
- Grant X:
  - Next state = X_BUSY.
  - mem_cs = 1; mem_we = dm_we (for DM) or 0 (for IF).
  - mem_addr / mem_wdata loaded from requester X.
  - last_owner = X.
- In X_BUSY with mem_ack = 0:
  - All mem_* outputs hold their values.
  - Requester inputs are ignored.
- In X_BUSY with mem_ack = 1:
  - Next cycle: x_ack = 1.
  - For IF, or for a DM read, x_rdata <= mem_rdata.
  - For a DM write, dm_rdata is unchanged.
  - The current owner is masked from arbitration this cycle, because its req is still high.
  - Other requester pending: grant it immediately (back-to-back, mem_cs stays 1).
  - Otherwise: state = IDLE, mem_cs = 0.
- If a requester keeps req high in its ack cycle, that is a new request with new address/data, and it is arbitrated normally.
- Reset values:
  - State IDLE, last_owner IF.
  - if_ack, dm_ack, mem_cs, mem_we, busy = 0.
  - if_rdata, dm_rdata, mem_addr, mem_wdata = 0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. The memory is reset by the same signal.

## Timing
- Request seen in IDLE at cycle t: mem_cs = 1 at t+1.
- mem_ack at t+1+L, with L ≥ 0: x_ack and x_rdata at t+2+L.
- Minimum latency is therefore 2 cycles.
- Back-to-back handoff: no mem_cs bubble. The address changes on the cycle after mem_ack.
- The ack pulse is exactly 1 cycle. rdata holds until the next completion for that port.
- Combinational paths:
  - x_req → x_stall
  - x_ack → x_stall
- All other outputs are registered.
- Simultaneous dm_req and if_req rising in IDLE right after reset: DM is granted first, then IF.

## Test plan
- Single fetch, L=0:
  - Stimulus: if_req/if_addr=0x0000_0040 at t; mem_ack in the first cs cycle with mem_rdata=0x2008_0005.
  - Required: mem_cs at t+1 with mem_addr=0x40 and mem_we=0; if_ack with if_rdata=0x2008_0005 at t+2; if_stall high at t and t+1.
- Data write, L=3:
  - Stimulus: dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF.
  - Required: mem_* held stable for 4 cycles; dm_ack one cycle after mem_ack; dm_rdata unchanged.
- Contention after reset:
  - Stimulus: if_req and dm_req at the same cycle.
  - Required: DM served first, then IF back-to-back with no mem_cs=0 cycle between; busy high throughout.
- Fairness:
  - Stimulus: both requesters hold req continuously, re-requesting in each ack cycle.
  - Required: grants alternate DM, IF, DM, IF; no port is granted twice in a row.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously during DM_BUSY with L=5.
  - Required: mem_cs, busy, and acks go to 0 immediately; no dm_ack after release; the next request starts cleanly.
- Pipelined fetch stream:
  - Stimulus: if_req held high, address +4 each ack cycle, L=0.
  - Required: one fetch completes every 2 cycles with correct address order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares a single req/ack memory port between instruction fetch and data access.
// Contention is resolved by alternating ownership; completions are returned as one-cycle acks.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_dm_q, last_dm_d;
    logic                  if_ack_q, if_ack_d;
    logic                  dm_ack_q, dm_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic arb_en;
    logic if_elig;
    logic dm_elig;
    logic grant_if;
    logic grant_dm;

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arb_en      = 1'b0;
        if_elig     = 1'b0;
        dm_elig     = 1'b0;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;

        // The finishing owner still holds req this cycle, so only the other port may win.
        case (state_q)
            IDLE: begin
                arb_en  = 1'b1;
                if_elig = if_req;
                dm_elig = dm_req;
            end
            IF_BUSY: begin
                if (mem_ack) begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                    arb_en     = 1'b1;
                    dm_elig    = dm_req;
                end
            end
            DM_BUSY: begin
                if (mem_ack) begin
                    dm_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    arb_en  = 1'b1;
                    if_elig = if_req;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        grant_dm = arb_en & dm_elig & (~if_elig | ~last_dm_q);
        grant_if = arb_en & if_elig & ~grant_dm;

        if (grant_dm) begin
            state_d     = DM_BUSY;
            last_dm_d   = 1'b1;
            mem_cs_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (grant_if) begin
            state_d     = IF_BUSY;
            last_dm_d   = 1'b0;
            mem_cs_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end else if (arb_en) begin
            state_d  = IDLE;
            mem_cs_d = 1'b0;
            mem_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign if_stall  = if_req & ~if_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized requesters and a variable-latency memory,
// checked every cycle against a transaction-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    // Handshake: a requester raises x_req with stable fields and holds them until the cycle
    // x_ack is high; keeping x_req high in that cycle presents a new request.
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 16) return 32'h2008_0005;
        return 32'hA500_0000 | (32'(i) * 32'h0001_0101);
    endfunction

    // Knobs written only by the main sequence
    int            if_prob = 0, if_limit = 0;
    logic [AW-1:0] if_base = '0;
    int            dm_prob = 0, dm_limit = 0, dm_we_pct = 0;
    bit            dm_rand_addr = 1'b0, dm_fix_data = 1'b0;
    logic [AW-1:0] dm_base = 32'h100;
    logic [DW-1:0] dm_fix_value = '0;
    int            lat_fixed = 0;

    int if_issued = 0, dm_issued = 0;

    // Fetch requester: IF region is 0x000-0x0FC, sequential from if_base
    initial forever begin
        @(posedge clk); #1;
        if (reset) if_req = 1'b0;
        else if (!if_req || if_ack) begin
            if (if_issued < if_limit && int'($urandom_range(99)) < if_prob) begin
                if_addr = (if_base + 32'(if_issued) * 4) & 32'h0000_00FC;
                if_req  = 1'b1;
                if_issued++;
            end else if_req = 1'b0;
        end
    end

    // Data requester: DM region starts at 0x100
    initial forever begin
        @(posedge clk); #1;
        if (reset) dm_req = 1'b0;
        else if (!dm_req || dm_ack) begin
            if (dm_issued < dm_limit && int'($urandom_range(99)) < dm_prob) begin
                dm_addr  = dm_rand_addr ? 32'h100 + 32'($urandom_range(15)) * 4 : dm_base;
                dm_we    = int'($urandom_range(99)) < dm_we_pct;
                dm_wdata = dm_fix_data ? dm_fix_value : $urandom;
                dm_req   = 1'b1;
                dm_issued++;
            end else dm_req = 1'b0;
        end
    end

    // Memory responder with programmable or random latency
    logic [DW-1:0] ram [256];
    int            obs_grants[$];
    int            lat_cnt = 0;
    bit            in_txn = 1'b0;
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_ack = 1'b0;
                in_txn  = 1'b0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    in_txn  = 1'b0;
                end
                if (mem_cs && !in_txn) begin
                    in_txn  = 1'b1;
                    lat_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(4));
                    obs_grants.push_back(mem_addr < 32'h100 ? 1 : 2);
                end
                if (in_txn && lat_cnt == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        ram[mem_addr[9:2]] = mem_wdata;
                        mem_rdata = $urandom;
                    end else mem_rdata = ram[mem_addr[9:2]];
                end else begin
                    if (in_txn) lat_cnt--;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Transaction-level model: owner 0=none 1=IF 2=DM; expected read data from a shadow memory
    int            m_owner = 0, m_last = 1, pick = 0;
    logic          m_if_ack = 1'b0, m_dm_ack = 1'b0, m_cs = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    logic [DW-1:0] ref_ram [256];
    bit            ref_init = 1'b0, fin = 1'b0, can_if = 1'b0, can_dm = 1'b0;
    logic [DW-1:0] if_exp_q[$];
    logic [DW:0]   dm_exp_q[$];
    logic [DW:0]   e;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            if (!ref_init) begin
                for (int i = 0; i < 256; i++) ref_ram[i] = init_word(i);
                ref_init = 1'b1;
            end
            m_owner = 0; m_last = 1; m_if_ack = 1'b0; m_dm_ack = 1'b0;
            m_cs = 1'b0; m_we = 1'b0; m_if_rdata = '0; m_dm_rdata = '0;
            if_exp_q.delete();
            dm_exp_q.delete();
        end else begin
            fin      = (m_owner != 0) && mem_ack;
            m_if_ack = fin && (m_owner == 1);
            m_dm_ack = fin && (m_owner == 2);
            if (m_if_ack) m_if_rdata = if_exp_q.pop_front();
            if (m_dm_ack) begin
                e = dm_exp_q.pop_front();
                if (!e[DW]) m_dm_rdata = e[DW-1:0];
            end
            if (m_owner == 0 || fin) begin
                can_if = if_req && !m_if_ack;
                can_dm = dm_req && !m_dm_ack;
                if (can_if && can_dm) pick = (m_last == 1) ? 2 : 1;
                else if (can_if) pick = 1;
                else if (can_dm) pick = 2;
                else pick = 0;
                m_owner = pick;
                if (pick == 1) begin
                    m_cs = 1'b1; m_we = 1'b0; m_addr = if_addr; m_last = 1;
                    if_exp_q.push_back(ref_ram[if_addr[9:2]]);
                end else if (pick == 2) begin
                    m_cs = 1'b1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_last = 2;
                    if (dm_we) begin
                        ref_ram[dm_addr[9:2]] = dm_wdata;
                        dm_exp_q.push_back({1'b1, dm_wdata});
                    end else dm_exp_q.push_back({1'b0, ref_ram[dm_addr[9:2]]});
                end else begin
                    m_cs = 1'b0; m_we = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            check("if_ack", if_ack, m_if_ack);
            check("dm_ack", dm_ack, m_dm_ack);
            check("mem_cs", mem_cs, m_cs);
            check("busy", busy, m_owner != 0);
            if (m_cs) begin
                check("mem_we", mem_we, m_we);
                check("mem_addr", mem_addr, m_addr);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("if_stall", if_stall, if_req & ~m_if_ack);
            check("dm_stall", dm_stall, dm_req & ~m_dm_ack);
            check("if_rdata", if_rdata, m_if_rdata);
            check("dm_rdata", dm_rdata, m_dm_rdata);
        end
    end

    task automatic wait_done(input int maxc);
        int n = 0;
        while ((if_issued < if_limit) || (dm_issued < dm_limit) || if_req || dm_req ||
               busy || if_ack || dm_ack) begin
            @(negedge clk);
            n++;
            if (n > maxc) break;
        end
        check("wait_done_in_budget", n > maxc, 1'b0);
    endtask

    int ack_cyc[$];
    logic [DW-1:0] ack_dat[$];
    int n_wait, fs;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_if_ack", if_ack, 0);        check("rst_dm_ack", dm_ack, 0);
        check("rst_mem_cs", mem_cs, 0);        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);            check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);    check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);

        // Contention right after reset: DM first, then IF back-to-back
        lat_fixed = 1; if_base = 32'h80; dm_base = 32'h100; dm_we_pct = 0;
        if_prob = 100; dm_prob = 100; if_limit = if_issued + 1; dm_limit = dm_issued + 1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("ct_t0_if_stall", if_stall, 1); check("ct_t0_dm_stall", dm_stall, 1);
        check("ct_t0_mem_cs", mem_cs, 0);
        @(negedge clk);
        check("ct_t1_mem_cs", mem_cs, 1); check("ct_t1_addr", mem_addr, 32'h100);
        check("ct_t1_busy", busy, 1);
        @(negedge clk);
        check("ct_t2_mem_cs", mem_cs, 1); check("ct_t2_busy", busy, 1);
        @(negedge clk);
        check("ct_t3_dm_ack", dm_ack, 1); check("ct_t3_mem_cs", mem_cs, 1);
        check("ct_t3_addr", mem_addr, 32'h80); check("ct_t3_busy", busy, 1);
        check("ct_t3_dm_rdata", dm_rdata, init_word(64));
        @(negedge clk);
        check("ct_t4_mem_cs", mem_cs, 1); check("ct_t4_busy", busy, 1);
        @(negedge clk);
        check("ct_t5_if_ack", if_ack, 1); check("ct_t5_if_rdata", if_rdata, init_word(32));
        check("ct_t5_mem_cs", mem_cs, 0); check("ct_t5_busy", busy, 0);
        wait_done(20);

        // Single fetch, zero memory latency
        lat_fixed = 0; if_base = 32'h40 - 32'(if_issued) * 4; if_limit = if_issued + 1;
        @(negedge clk);
        check("sf_t0_if_stall", if_stall, 1); check("sf_t0_mem_cs", mem_cs, 0);
        @(negedge clk);
        check("sf_t1_mem_cs", mem_cs, 1); check("sf_t1_addr", mem_addr, 32'h40);
        check("sf_t1_we", mem_we, 0); check("sf_t1_if_stall", if_stall, 1);
        @(negedge clk);
        check("sf_t2_if_ack", if_ack, 1); check("sf_t2_if_rdata", if_rdata, 32'h2008_0005);
        check("sf_t2_mem_cs", mem_cs, 0);
        @(negedge clk);
        check("sf_t3_if_ack", if_ack, 0); check("sf_t3_if_rdata", if_rdata, 32'h2008_0005);
        wait_done(20);

        // Data write, latency 3
        lat_fixed = 3; dm_base = 32'h100; dm_we_pct = 100; dm_fix_data = 1'b1;
        dm_fix_value = 32'hDEAD_BEEF; dm_limit = dm_issued + 1;
        @(negedge clk);
        check("dw_t0_dm_stall", dm_stall, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("dw_hold_cs", mem_cs, 1); check("dw_hold_we", mem_we, 1);
            check("dw_hold_addr", mem_addr, 32'h100); check("dw_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("dw_hold_no_ack", dm_ack, 0);
        end
        @(negedge clk);
        check("dw_t5_dm_ack", dm_ack, 1); check("dw_t5_dm_rdata", dm_rdata, init_word(64));
        @(negedge clk);
        check("dw_t6_dm_ack", dm_ack, 0);
        wait_done(20);

        // Reset in the middle of a DM read
        lat_fixed = 5; dm_base = 32'h104; dm_we_pct = 0; dm_fix_data = 1'b0; dm_limit = dm_issued + 1;
        repeat (3) @(negedge clk);
        check("rm_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("rm_mem_cs", mem_cs, 0); check("rm_busy", busy, 0);
        check("rm_dm_ack", dm_ack, 0); check("rm_if_ack", if_ack, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rm_no_dm_ack", dm_ack, 0); check("rm_idle_cs", mem_cs, 0);
        end
        lat_fixed = 2; if_base = 32'h44 - 32'(if_issued) * 4; if_limit = if_issued + 1;
        n_wait = 0;
        do begin
            @(negedge clk);
            n_wait++;
        end while (!if_ack && n_wait < 15);
        check("rm_restart_latency", n_wait, 5);
        check("rm_restart_rdata", if_rdata, init_word(17));
        wait_done(20);

        // Pipelined fetch stream, one completion every 2 cycles
        lat_fixed = 0; if_base = 32'h0 - 32'(if_issued) * 4; if_limit = if_issued + 8;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if_ack) begin
                ack_cyc.push_back(c);
                ack_dat.push_back(if_rdata);
            end
        end
        check("pf_count", ack_cyc.size(), 8);
        for (int k = 0; k < ack_cyc.size(); k++) begin
            check("pf_order", ack_dat[k], init_word(k));
            if (k > 0) check("pf_spacing", ack_cyc[k] - ack_cyc[k-1], 2);
        end
        wait_done(20);

        // Fairness: both hold requests continuously
        lat_fixed = -1; dm_rand_addr = 1'b1; dm_we_pct = 50;
        fs = obs_grants.size();
        if_limit = if_issued + 10; dm_limit = dm_issued + 10;
        wait_done(400);
        check("fair_grants", obs_grants.size() - fs, 20);
        if (obs_grants.size() > fs) check("fair_first_dm", obs_grants[fs], 2);
        for (int k = fs + 1; k < obs_grants.size(); k++)
            check("fair_alternate", obs_grants[k] == obs_grants[k-1], 1'b0);

        // Random traffic
        if_prob = 40; dm_prob = 50; dm_we_pct = 40;
        if_limit = if_issued + 150; dm_limit = dm_issued + 150;
        wait_done(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
